// File: rtl/bullet_pool_pkg.sv
// -----------------------------------------------------------------------------
// GamePkg
// Shared game geometry constants and the bullet record type used by the
// bullet pool and its per-slot logic. All sizes are half-extents in pixels
// measured from an object's centre, which keeps box overlap tests symmetric.
// -----------------------------------------------------------------------------
package GamePkg;

    localparam int MAP_X          = 640;
    localparam int MAP_Y          = 480;
    localparam int BULLET_X       = 4;
    localparam int BULLET_Y       = 2;
    localparam int PLAYER_X       = 16;
    localparam int PLAYER_Y       = 24;
    localparam int SQUAT_PLAYER_Y = 12;
    localparam int BULLET_STEP_X  = 8;

    // One bullet slot: occupancy flag plus signed centre coordinates.
    typedef struct packed {
        logic              alive;
        logic signed [10:0] x;
        logic signed [9:0]  y;
    } bullet_t;

endpackage

// File: rtl/bullet_pool_slot.sv
// -----------------------------------------------------------------------------
// bullet_slot
// Holds one bullet. On a tick it either accepts a fresh spawn (no motion, no
// hit test that tick) or, if alive, advances horizontally and retires itself
// when it strikes the target box or leaves the map.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  frame-update strobe
//   spawn                 load this slot with spawn_x/spawn_y this tick
//   spawn_x, spawn_y      spawn position
//   x_target, y_target    target centre
//   target_squat          selects the reduced target half-height
//   state                 registered slot contents
//   hit_now               this tick's move landed inside the target box
// -----------------------------------------------------------------------------
module bullet_slot
    import GamePkg::*;
#(
    parameter int STEP_X = BULLET_STEP_X,
    parameter int DIR    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               spawn,
    input  logic signed [10:0] spawn_x,
    input  logic signed [9:0]  spawn_y,
    input  logic signed [10:0] x_target,
    input  logic signed [9:0]  y_target,
    input  logic               target_squat,
    output bullet_t            state,
    output logic               hit_now
);

    localparam logic signed [11:0] STEP     = 12'(DIR * STEP_X);
    localparam logic signed [11:0] HIT_DX   = 12'(BULLET_X + PLAYER_X);
    localparam logic signed [10:0] HIT_DY   = 11'(BULLET_Y + PLAYER_Y);
    localparam logic signed [10:0] HIT_DY_S = 11'(BULLET_Y + SQUAT_PLAYER_Y);
    localparam logic signed [11:0] X_MAX    = 12'(MAP_X - BULLET_X);
    localparam logic signed [11:0] X_MIN    = 12'(BULLET_X);

    bullet_t            state_q, state_d;
    logic signed [11:0] x_new, dx, adx;
    logic signed [10:0] dy, ady;
    logic               in_box, off_screen;

    // Motion and the hit/off-screen tests are done one bit wider than the
    // stored coordinate so a step past the map edge cannot wrap around.
    always_comb begin
        x_new      = {state_q.x[10], state_q.x} + STEP;
        dx         = x_new - {x_target[10], x_target};
        adx        = dx[11] ? -dx : dx;
        dy         = {state_q.y[9], state_q.y} - {y_target[9], y_target};
        ady        = dy[10] ? -dy : dy;
        in_box     = (adx < HIT_DX) && (ady < (target_squat ? HIT_DY_S : HIT_DY));
        off_screen = (x_new > X_MAX) || (x_new < X_MIN);
        hit_now    = tick && state_q.alive && !spawn && in_box;

        state_d = state_q;
        if (tick) begin
            if (spawn) begin
                state_d.alive = 1'b1;
                state_d.x     = spawn_x;
                state_d.y     = spawn_y;
            end else if (state_q.alive) begin
                state_d.x = x_new[10:0];
                // A hit and an exit both retire the slot; the hit is what
                // gets reported, via hit_now.
                if (hit_now || off_screen) begin
                    state_d.alive = 1'b0;
                end
            end
        end
    end

    // Slot register; reset clears position too so outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bullet_pool.sv
// -----------------------------------------------------------------------------
// bullet_pool
// A fixed pool of bullet slots fired by one shooter at one target. The top
// level allocates the lowest free slot on an allowed attack, runs the
// inter-shot cooldown and reduces per-slot hits into a registered pulse and
// count.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   tick                   frame-update strobe; nothing changes without it
//   attack, defend         shooter controls (defend suppresses firing)
//   xShooter, yShooter     shooter centre
//   xTarget, yTarget       target centre
//   targetSquat            target is crouching (smaller box)
//   x, y                   packed signed bullet centres, slot i at 11i / 10i
//   alive                  per-slot occupancy
//   hit, hitCount          strike pulse and count for the previous tick
//   ready                  a shot would be accepted now
// -----------------------------------------------------------------------------
module bullet_pool
    import GamePkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int COOLDOWN    = 8,
    parameter int STEP_X      = BULLET_STEP_X,
    parameter int DIR         = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tick,
    input  logic                               attack,
    input  logic                               defend,
    input  logic signed [10:0]                 xShooter,
    input  logic signed [9:0]                  yShooter,
    input  logic signed [10:0]                 xTarget,
    input  logic signed [9:0]                  yTarget,
    input  logic                               targetSquat,
    output logic [NUM_BULLETS*11-1:0]          x,
    output logic [NUM_BULLETS*10-1:0]          y,
    output logic [NUM_BULLETS-1:0]             alive,
    output logic                               hit,
    output logic [$clog2(NUM_BULLETS+1)-1:0]   hitCount,
    output logic                               ready
);

    localparam int CNT_W = $clog2(NUM_BULLETS + 1);
    localparam logic signed [10:0] SPAWN_OFF = 11'(DIR * (PLAYER_X + BULLET_X));

    bullet_t                  slot_state [NUM_BULLETS];
    logic [NUM_BULLETS-1:0]   slot_hit, slot_spawn, free_mask;
    logic signed [10:0]       spawn_x;
    logic                     spawn_ok, attack_blocked, found;
    logic [7:0]               cooldown_q, cooldown_d;
    logic                     hit_q, hit_d;
    logic [CNT_W-1:0]         hit_count_q, hit_count_d;

    assign spawn_x = xShooter + SPAWN_OFF;

    // Allocation looks only at registered occupancy, so a slot freed on this
    // tick cannot be refilled until the next one.
    always_comb begin
        spawn_ok       = tick && attack && !defend && (cooldown_q == 8'd0) && (|free_mask);
        attack_blocked = attack && (defend || !(|free_mask));
        slot_spawn     = '0;
        found          = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (spawn_ok && free_mask[i] && !found) begin
                slot_spawn[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Cooldown reloads on a shot and otherwise runs down per tick, except
    // that a refused attack freezes it where it stands.
    always_comb begin
        cooldown_d = cooldown_q;
        if (tick) begin
            if (spawn_ok) begin
                cooldown_d = 8'(COOLDOWN);
            end else if (!attack_blocked && (cooldown_q != 8'd0)) begin
                cooldown_d = cooldown_q - 8'd1;
            end
        end
    end

    // Hit reduction; slot_hit is already qualified by tick, so outside a tick
    // this yields zero and the registered outputs fall back to 0.
    always_comb begin
        hit_d       = |slot_hit;
        hit_count_d = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hit_count_d = hit_count_d + CNT_W'(slot_hit[i]);
        end
    end

    // Cooldown and hit reporting registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown_q  <= '0;
            hit_q       <= 1'b0;
            hit_count_q <= '0;
        end else begin
            cooldown_q  <= cooldown_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        bullet_slot #(
            .STEP_X (STEP_X),
            .DIR    (DIR)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .spawn        (slot_spawn[i]),
            .spawn_x      (spawn_x),
            .spawn_y      (yShooter),
            .x_target     (xTarget),
            .y_target     (yTarget),
            .target_squat (targetSquat),
            .state        (slot_state[i]),
            .hit_now      (slot_hit[i])
        );

        assign free_mask[i]      = !slot_state[i].alive;
        assign alive[i]          = slot_state[i].alive;
        assign x[11*i +: 11]     = slot_state[i].x;
        assign y[10*i +: 10]     = slot_state[i].y;
    end

    assign hit      = hit_q;
    assign hitCount = hit_count_q;
    assign ready    = (cooldown_q == 8'd0) && (|free_mask);

endmodule

// File: tb/tb_bullet_pool.sv
// -----------------------------------------------------------------------------
// tb_bullet_pool
// Directed bench for bullet_pool. A rightward pool (4 slots, cooldown 3) and a
// leftward pool (2 slots, cooldown 0) share clock, reset and tick.
// -----------------------------------------------------------------------------
module tb_bullet_pool;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic               attack = 1'b0;
    logic               defend = 1'b0;
    logic               target_squat = 1'b0;
    logic signed [10:0] x_shooter = 11'sd100;
    logic signed [9:0]  y_shooter = 10'sd200;
    logic signed [10:0] x_target = 11'sd1000;
    logic signed [9:0]  y_target = -10'sd500;
    logic [43:0]        x;
    logic [39:0]        y;
    logic [3:0]         alive;
    logic               hit;
    logic [2:0]         hit_count;
    logic               ready;

    logic               l_attack = 1'b0;
    logic signed [10:0] l_x_shooter = 11'sd100;
    logic signed [9:0]  l_y_shooter = 10'sd50;
    logic signed [10:0] l_x_target = -11'sd1000;
    logic signed [9:0]  l_y_target = -10'sd500;
    logic [21:0]        l_x;
    logic [19:0]        l_y;
    logic [1:0]         l_alive;
    logic               l_hit;
    logic [1:0]         l_hit_count;
    logic               l_ready;

    int check_count = 0;
    int error_count = 0;
    int exp_x;

    bullet_pool #(
        .NUM_BULLETS (4),
        .COOLDOWN    (3),
        .STEP_X      (8),
        .DIR         (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .attack      (attack),
        .defend      (defend),
        .xShooter    (x_shooter),
        .yShooter    (y_shooter),
        .xTarget     (x_target),
        .yTarget     (y_target),
        .targetSquat (target_squat),
        .x           (x),
        .y           (y),
        .alive       (alive),
        .hit         (hit),
        .hitCount    (hit_count),
        .ready       (ready)
    );

    bullet_pool #(
        .NUM_BULLETS (2),
        .COOLDOWN    (0),
        .STEP_X      (8),
        .DIR         (-1)
    ) dut_left (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .attack      (l_attack),
        .defend      (defend),
        .xShooter    (l_x_shooter),
        .yShooter    (l_y_shooter),
        .xTarget     (l_x_target),
        .yTarget     (l_y_target),
        .targetSquat (target_squat),
        .x           (l_x),
        .y           (l_y),
        .alive       (l_alive),
        .hit         (l_hit),
        .hitCount    (l_hit_count),
        .ready       (l_ready)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One tick strobe; returns 1 ns after the capturing edge.
    task automatic applyStimulus();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic applyReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_alive", 64'(alive), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state.
        #12;
        checkOutput("rst_x", 64'(x), 64'd0);
        checkOutput("rst_y", 64'(y), 64'd0);
        checkOutput("rst_alive", 64'(alive), 64'd0);
        checkOutput("rst_hit", 64'(hit), 64'd0);
        checkOutput("rst_hitcount", 64'(hit_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_l_ready", 64'(l_ready), 64'd1);

        // Held attack: spawns on ticks 0, 4, 8, 12 into slots 0..3.
        attack = 1'b1;
        for (int t = 0; t < 20; t++) begin
            applyStimulus();
            checkOutput("hold_alive", 64'(alive),
                        (t < 4) ? 64'd1 : (t < 8) ? 64'd3 : (t < 12) ? 64'd7 : 64'd15);
            checkOutput("hold_ready", 64'(ready), ((t < 12) && (t % 4 == 3)) ? 64'd1 : 64'd0);
        end
        checkOutput("hold_x0", 64'(x[10:0]), 64'd272);
        checkOutput("hold_x1", 64'(x[21:11]), 64'd240);
        checkOutput("hold_x3", 64'(x[43:33]), 64'd176);
        checkOutput("hold_y2", 64'(y[29:20]), 64'd200);

        // Slot 0 flies on to the right edge and retires past MAP_X-BULLET_X.
        attack = 1'b0;
        exp_x = 272;
        for (int k = 0; k < 46; k++) begin
            applyStimulus();
            exp_x += 8;
            checkOutput("fly_x0", 64'(x[10:0]), 64'(exp_x));
            checkOutput("fly_alive0", 64'(alive[0]), (exp_x <= 636) ? 64'd1 : 64'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("dead_x0_hold", 64'(x[10:0]), 64'd640);
        checkOutput("fly_alive_rest", 64'(alive), 64'd14);

        // Mid-flight reset clears everything without waiting for an edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_alive", 64'(alive), 64'd0);
        checkOutput("async_x", 64'(x), 64'd0);
        checkOutput("async_y", 64'(y), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two bullets 32 px apart reach the target box on the same tick.
        x_shooter = 11'sd100;
        y_shooter = 10'sd200;
        attack = 1'b1;
        for (int t = 0; t < 5; t++) applyStimulus();
        attack = 1'b0;
        checkOutput("pair_alive", 64'(alive), 64'd3);
        checkOutput("pair_x0", 64'(x[10:0]), 64'd152);
        checkOutput("pair_x1", 64'(x[21:11]), 64'd120);
        x_target = 11'sd144;
        y_target = 10'sd200;
        applyStimulus();
        checkOutput("pair_hit", 64'(hit), 64'd1);
        checkOutput("pair_hitcount", 64'(hit_count), 64'd2);
        checkOutput("pair_alive_after", 64'(alive), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("pair_hit_drop", 64'(hit), 64'd0);
        checkOutput("pair_hitcount_drop", 64'(hit_count), 64'd0);

        // Bullet 20 px above target centre: misses a squat, hits a stander.
        applyReset();
        target_squat = 1'b1;
        x_target = 11'sd140;
        y_target = 10'sd200;
        y_shooter = 10'sd220;
        attack = 1'b1;
        applyStimulus();
        attack = 1'b0;
        applyStimulus();
        checkOutput("squat_hit", 64'(hit), 64'd0);
        checkOutput("squat_alive", 64'(alive), 64'd1);
        target_squat = 1'b0;
        applyStimulus();
        checkOutput("stand_hit", 64'(hit), 64'd1);
        checkOutput("stand_hitcount", 64'(hit_count), 64'd1);
        checkOutput("stand_alive", 64'(alive), 64'd0);

        // Defend blocks firing and freezes the cooldown.
        applyReset();
        x_target = 11'sd1000;
        y_target = -10'sd500;
        attack = 1'b1;
        defend = 1'b1;
        for (int t = 0; t < 5; t++) begin
            applyStimulus();
            checkOutput("defend_alive", 64'(alive), 64'd0);
            checkOutput("defend_ready", 64'(ready), 64'd1);
        end
        defend = 1'b0;
        applyStimulus();
        checkOutput("shot_alive", 64'(alive), 64'd1);
        defend = 1'b1;
        for (int t = 0; t < 5; t++) begin
            applyStimulus();
            checkOutput("freeze_ready", 64'(ready), 64'd0);
        end
        checkOutput("freeze_alive", 64'(alive), 64'd1);
        attack = 1'b0;
        defend = 1'b0;
        for (int t = 0; t < 3; t++) begin
            applyStimulus();
            checkOutput("drain_ready", 64'(ready), (t == 2) ? 64'd1 : 64'd0);
        end

        // Leftward pool: spawns at 80, steps -8, retires once x < BULLET_X.
        applyReset();
        l_attack = 1'b1;
        applyStimulus();
        l_attack = 1'b0;
        checkOutput("left_spawn_x", 64'(l_x[10:0]), 64'd80);
        checkOutput("left_spawn_y", 64'(l_y[9:0]), 64'd50);
        exp_x = 80;
        for (int k = 0; k < 10; k++) begin
            applyStimulus();
            exp_x -= 8;
            checkOutput("left_x0", 64'(l_x[10:0]), 64'(exp_x));
            checkOutput("left_alive0", 64'(l_alive[0]), (exp_x >= 4) ? 64'd1 : 64'd0);
        end
        checkOutput("left_hit", 64'(l_hit), 64'd0);
        checkOutput("left_hitcount", 64'(l_hit_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 SHALL have parameter NUM_BULLETS, default 4: number of independent bullet slots, range 1..16.
REQ-002 SHALL have parameter COOLDOWN, default 8: ticks between consecutive spawns, range 0..255.
REQ-003 SHALL have parameter STEP_X, default BULLET_STEP_X: horizontal pixels moved per tick.
REQ-004 SHALL have parameter DIR, default 1: +1 fires rightward (player), -1 fires leftward (enemy).
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port tick, input, 1 bit: frame-update strobe; all motion, spawn and hit evaluation occurs only on clk edges where tick=1.
REQ-008 SHALL have ports attack and defend, input, 1 bit each: shooter controls.
REQ-009 SHALL have ports xShooter (signed 11) and yShooter (signed 10), input: shooter centre.
REQ-010 SHALL have ports xTarget (signed 11) and yTarget (signed 10), input: target centre.
REQ-011 SHALL have port targetSquat, input, 1 bit: when 1, target half-height is SQUAT_PLAYER_Y, otherwise PLAYER_Y.
REQ-012 SHALL have port x, output, NUM_BULLETS*11 bits: signed bullet centres, slot i at bits [11i+10:11i].
REQ-013 SHALL have port y, output, NUM_BULLETS*10 bits: packed the same way as x.
REQ-014 SHALL have port alive, output, NUM_BULLETS bits: slot-occupied flags.
REQ-015 SHALL have port hit, output, 1 bit: one-cycle pulse when at least one bullet struck the target on the last tick.
REQ-016 SHALL have port hitCount, output, $clog2(NUM_BULLETS+1) bits: number of bullets that struck on the last tick.
REQ-017 SHALL have port ready, output, 1 bit: cooldown is 0 and at least one slot is free.

Function
REQ-018 On a tick, each alive slot SHALL update x to x + DIR*STEP_X, computed at 12-bit signed width; y SHALL not change.
REQ-019 A moved slot SHALL count as a hit when |xNew-xTarget| < BULLET_X+PLAYER_X and |y-yTarget| < BULLET_Y+half-height (the target box from REQ-011).
- A hit SHALL clear the slot's alive bit.
REQ-020 A moved, non-hit slot SHALL clear alive when xNew > MAP_X-BULLET_X or xNew < BULLET_X.
- A hit SHALL take priority over off-screen in the same tick.
REQ-021 A spawn SHALL occur on a tick when attack=1, defend=0, cooldown=0 and a slot was free before this tick's frees.
- The spawn SHALL use the lowest-index free slot.
- Spawn position: x = xShooter + DIR*(PLAYER_X+BULLET_X), y = yShooter.
- Slots freed in the same tick SHALL become usable on the next tick.
REQ-022 A freshly spawned slot SHALL NOT move and SHALL NOT be hit-tested on its spawn tick.
REQ-023 At most one spawn SHALL occur per tick.
REQ-024 The cooldown counter SHALL load COOLDOWN on a spawn.
- Otherwise it SHALL decrement on each tick while nonzero.
- An attack that is blocked (pool full or defend=1) SHALL leave the cooldown unchanged.
REQ-025 hit and hitCount SHALL be registered, valid for exactly the one cycle after the tick, and 0 at all other times.
REQ-026 With tick=0, all state SHALL hold, and x/y of dead slots SHALL hold their last value.
REQ-027 The ready output SHALL be combinational from registered state only.

Reset
REQ-028 While rst_n=0, all outputs SHALL be forced to 0: alive, x, y, hit and hitCount, with cooldown=0.
REQ-029 Reset SHALL abort all in-flight bullets; the first tick after release behaves as for an empty pool.

Structure
REQ-030 Constants BULLET_X, BULLET_Y, PLAYER_X, PLAYER_Y, SQUAT_PLAYER_Y, MAP_X and BULLET_STEP_X SHALL come from GamePkg.
- GamePkg SHALL also define a bullet_t struct {alive, x, y} for shared use.
REQ-031 Per-slot motion, hit and off-screen logic SHALL live in sub-module bullet_slot, instantiated NUM_BULLETS times by generate.
- The top level owns the slot allocator, cooldown counter and hit reduction.

Verification
REQ-032 With N=4, COOLDOWN=3 and attack held for 20 ticks, spawns SHALL occur on ticks 0, 4, 8 and 12 into slots 0..3; ready SHALL be 0 while the pool is full.
REQ-033 With xShooter=100 and target far away, the slot-0 x sequence SHALL be 100+PLAYER_X+BULLET_X, then +STEP_X each tick, until alive drops once x > MAP_X-BULLET_X.
REQ-034 With the target placed so two bullets enter its box on the same tick, hit SHALL pulse once, hitCount SHALL be 2, and both alive bits SHALL clear.
REQ-035 With a bullet y between yTarget+SQUAT_PLAYER_Y+BULLET_Y and yTarget+PLAYER_Y+BULLET_Y:
- targetSquat=1 SHALL produce no hit;
- targetSquat=0 SHALL produce a hit.
REQ-036 With defend=1 and attack=1 for 5 ticks, there SHALL be no spawn and cooldown SHALL be unchanged.
REQ-037 With DIR=-1, a bullet SHALL travel leftward and free itself once x < BULLET_X.
REQ-038 Asserting rst_n=0 mid-flight SHALL clear all alive bits immediately, asynchronously.
